// File: rtl/cfu_simd_macc_if.sv
// cfu_simd_macc_if: CFU command/response bus. master = CPU side, slave = CFU side.
//   cmd_*  : command channel (valid/ready, 10-bit function id, two 32-bit operands)
//   rsp_*  : response channel (valid/ready, ok flag, 32-bit result)
interface cfu_simd_macc_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_payload_response_ok;
  logic [31:0] rsp_payload_outputs_0;
  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0
  );
  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_simd_macc.sv
// cfu_simd_macc: SIMD multiply-accumulate CFU with input offset and NUM_ACC accumulators.
//   clk, reset (async, active-high); bus = cfu_simd_macc_if.slave command/response channels.
//   funct3: 0 SET_OFFSET, 1 SET_ACC, 2 MACC, 3 GET_ACC, 4 GET_CLEAR, 5..7 illegal.
//   Define CFU_MACC_SATURATE_EN to make the MACC accumulator update saturate instead of wrap.
module cfu_simd_macc #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 32,
  parameter int NUM_ACC = 4
) (
  input logic            clk,
  input logic            reset,
  cfu_simd_macc_if.slave bus
);
  localparam int LANES = 32 / IN_W;
  localparam int SEL_W = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1;
`ifdef CFU_MACC_SATURATE_EN
  localparam int SUM_W = ACC_W + $clog2(LANES) + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
`else
  localparam int SUM_W = ACC_W;
`endif
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [NUM_ACC];
  logic signed [ACC_W-1:0] acc_d [NUM_ACC];
  logic signed [ACC_W-1:0] prod_q [LANES];
  logic signed [ACC_W-1:0] prod_d [LANES];
  logic signed [31:0]      offset_q, offset_d;
  logic [SEL_W-1:0]        sel_q, sel_d, sel;
  logic [31:0]             out_q, out_d;
  logic                    ok_q, ok_d;
  logic [2:0]              funct3;
  logic                    accept;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_new;
  logic                    unused_funct7;
  assign funct3        = bus.cmd_payload_function_id[2:0];
  assign sel           = bus.cmd_payload_function_id[3 +: SEL_W] & SEL_W'(NUM_ACC - 1);
  assign accept        = bus.cmd_valid && state_q == IDLE;
  assign unused_funct7 = ^bus.cmd_payload_function_id[9:3+SEL_W];
  assign bus.cmd_ready               = state_q == IDLE;
  assign bus.rsp_valid               = state_q == RESP;
  assign bus.rsp_payload_response_ok = ok_q;
  assign bus.rsp_payload_outputs_0   = out_q;
  // Sum is formed from registered products so the multiplier and adder tree sit in separate cycles.
  always_comb begin
    sum = SUM_W'(acc_q[sel_q]);
    for (int k = 0; k < LANES; k++) sum = sum + SUM_W'(prod_q[k]);
`ifdef CFU_MACC_SATURATE_EN
    acc_new = sum > SAT_MAX ? ACC_W'(SAT_MAX) : sum < SAT_MIN ? ACC_W'(SAT_MIN) : ACC_W'(sum);
`else
    acc_new = sum;
`endif
  end
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    offset_d = offset_q;
    sel_d    = sel_q;
    out_d    = out_q;
    ok_d     = ok_q;
    if (accept) begin
      sel_d   = sel;
      ok_d    = 1'b1;
      out_d   = bus.cmd_payload_inputs_0;
      state_d = RESP;
      case (funct3)
        3'd0: offset_d = bus.cmd_payload_inputs_0;
        3'd1: acc_d[sel] = ACC_W'($signed(bus.cmd_payload_inputs_0));
        3'd2: begin
          state_d = MUL;
          // (inp + offset) needs 33 bits so a full-range offset cannot overflow the operand.
          for (int k = 0; k < LANES; k++)
            prod_d[k] = ACC_W'($signed(bus.cmd_payload_inputs_0[k*IN_W +: IN_W])) *
                        ACC_W'(33'($signed(bus.cmd_payload_inputs_1[k*IN_W +: IN_W])) + 33'(offset_q));
        end
        3'd3: out_d = acc_q[sel][31:0];
        3'd4: begin
          out_d      = acc_q[sel][31:0];
          acc_d[sel] = '0;
        end
        default: begin
          ok_d  = 1'b0;
          out_d = '0;
        end
      endcase
    end else if (state_q == MUL) begin
      acc_d[sel_q] = acc_new;
      out_d        = acc_new[31:0];
      state_d      = RESP;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '{default: '0};
      prod_q   <= '{default: '0};
      offset_q <= '0;
      sel_q    <= '0;
      out_q    <= '0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      offset_q <= offset_d;
      sel_q    <= sel_d;
      out_q    <= out_d;
      ok_q     <= ok_d;
    end
  end
endmodule

// File: tb/tb_cfu_simd_macc.sv
// tb_cfu_simd_macc: directed scoreboard bench for cfu_simd_macc (IN_W=8 and IN_W=16 instances).
module tb_cfu_simd_macc;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  cfu_simd_macc_if bus ();
  cfu_simd_macc_if bus16 ();
  cfu_simd_macc dut (.clk(clk), .reset(reset), .bus(bus));
  cfu_simd_macc #(.IN_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  typedef struct {
    logic        ok;
    logic [31:0] out;
    int          lat;
  } exp_t;
  exp_t sb[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Issue one command, check latency/payload against the scoreboard, optionally stall rsp_ready.
  task automatic run(input string tag, input logic [2:0] f3, input int sel, input logic [31:0] a,
                     input logic [31:0] b, input logic ok, input logic [31:0] exp, input int stall);
    exp_t        e;
    int          n;
    logic [31:0] held;
    sb.push_back('{ok, exp, f3 == 3'd2 ? 2 : 1});
    @(negedge clk);
    bus.rsp_ready = stall == 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {7'(sel), f3};
    bus.cmd_payload_inputs_0 = a;
    bus.cmd_payload_inputs_1 = b;
    n = 0;
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n++;
    end while (!bus.rsp_valid && n < 10);
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(n), 32'(e.lat));
    chk({tag, " ok"}, 32'(bus.rsp_payload_response_ok), 32'(e.ok));
    chk({tag, " out"}, bus.rsp_payload_outputs_0, e.out);
    held = bus.rsp_payload_outputs_0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, " stall valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " stall out"}, bus.rsp_payload_outputs_0, held);
      chk({tag, " stall cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, " post cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, " post rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask
  initial begin
    int n;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0 = '0;
    bus.cmd_payload_inputs_1 = '0;
    bus.rsp_ready = 1'b1;
    bus16.cmd_valid = 1'b0;
    bus16.cmd_payload_function_id = '0;
    bus16.cmd_payload_inputs_0 = '0;
    bus16.cmd_payload_inputs_1 = '0;
    bus16.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst out", bus.rsp_payload_outputs_0, 32'd0);
    chk("rst ok", 32'(bus.rsp_payload_response_ok), 32'd0);
    reset = 1'b0;
    run("set_off128", 3'd0, 0, 32'd128, 32'd0, 1'b1, 32'd128, 0);
    run("set_acc0", 3'd1, 0, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    run("macc_basic", 3'd2, 0, 32'h01020304, 32'hFFFFFFFF, 1'b1, 32'd1270, 0);
    run("get_acc0", 3'd3, 0, 32'd0, 32'd0, 1'b1, 32'd1270, 0);
    run("macc_stall", 3'd2, 0, 32'h00000001, 32'h00000000, 1'b1, 32'd1398, 3);
    run("set_off0", 3'd0, 0, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    run("set_acc1", 3'd1, 1, 32'd100, 32'd0, 1'b1, 32'd100, 0);
    run("set_acc2", 3'd1, 2, 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFB, 0);
    run("macc_sel1", 3'd2, 1, 32'h00000002, 32'h00000003, 1'b1, 32'd106, 0);
    run("get_acc2", 3'd3, 2, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFB, 0);
    run("get_clr1", 3'd4, 1, 32'd0, 32'd0, 1'b1, 32'd106, 0);
    run("get_acc1", 3'd3, 1, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    run("get_acc0_kept", 3'd3, 0, 32'd0, 32'd0, 1'b1, 32'd1398, 0);
    run("set_acc0_hi", 3'd1, 0, 32'h7FFFFFF0, 32'd0, 1'b1, 32'h7FFFFFF0, 0);
`ifdef CFU_MACC_SATURATE_EN
    run("macc_ovf", 3'd2, 0, 32'h00000001, 32'h00000020, 1'b1, 32'h7FFFFFFF, 0);
    run("illegal7", 3'd7, 0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0, 0);
    run("get_after_ill", 3'd3, 0, 32'd0, 32'd0, 1'b1, 32'h7FFFFFFF, 0);
`else
    run("macc_ovf", 3'd2, 0, 32'h00000001, 32'h00000020, 1'b1, 32'h80000010, 0);
    run("illegal7", 3'd7, 0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0, 0);
    run("get_after_ill", 3'd3, 0, 32'd0, 32'd0, 1'b1, 32'h80000010, 0);
`endif
    run("illegal5", 3'd5, 3, 32'h1, 32'h1, 1'b0, 32'd0, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_payload_function_id = {7'd0, 3'd2};
    bus.cmd_payload_inputs_0 = 32'h01010101;
    bus.cmd_payload_inputs_1 = 32'h01010101;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("mul rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mul cmd_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("aborted rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    run("get_acc0_rst", 3'd3, 0, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    run("get_acc2_rst", 3'd3, 2, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    run("macc_off_rst", 3'd2, 3, 32'h00000003, 32'h00000005, 1'b1, 32'd15, 0);
    @(negedge clk);
    bus16.cmd_valid = 1'b1;
    bus16.cmd_payload_function_id = {7'd0, 3'd2};
    bus16.cmd_payload_inputs_0 = 32'hFFFF0002;
    bus16.cmd_payload_inputs_1 = 32'h00030004;
    n = 0;
    do begin
      @(negedge clk);
      bus16.cmd_valid = 1'b0;
      n++;
    end while (!bus16.rsp_valid && n < 10);
    chk("w16 latency", 32'(n), 32'd2);
    chk("w16 out", bus16.rsp_payload_outputs_0, 32'd5);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cfu_simd_macc.md
Name: cfu_simd_macc

Overview:
- Multi-cycle CFU for quantised convolution inner loops on the CPU's custom-function-unit bus.
- Performs LANES-wide SIMD multiply-accumulate with a programmable input offset into one of NUM_ACC independent accumulators.
- Uses a full two-way handshake with back-pressure and a registered multiplier stage, so it can retire one MACC of 32/IN_W lanes per command.

Parameters:
- IN_W, 8, lane width in bits; legal values 8 or 16; LANES = 32/IN_W (derived localparam).
- ACC_W, 32, accumulator width in bits; must be >= 32.
- NUM_ACC, 4, number of accumulators; power of two, 1..16.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_payload_function_id  in  10  [2:0] = funct3 opcode; [9:3] = funct7, whose low log2(NUM_ACC) bits select the accumulator (sel)
- cmd_payload_inputs_0  in  32  in1, filter lanes
- cmd_payload_inputs_1  in  32  in2, input lanes
- rsp_valid  out  1  response available
- rsp_ready  in  1  CPU accepts response
- rsp_payload_response_ok  out  1  1 = legal opcode
- rsp_payload_outputs_0  out  32  result

Interface (already decided): one clock, clk; reset is asynchronous and active-high, named reset.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_payload_outputs_0=0, rsp_payload_response_ok=0.
  - All accumulators and input_offset cleared to 0.
- Lanes:
  - Lane k = bits [k*IN_W +: IN_W] of in1/in2, sign-extended.
  - Lane 0 is the least-significant lane.
- FSM states: IDLE, MUL, RESP.
  - cmd_ready = (state==IDLE).
  - A command is accepted on cmd_valid && cmd_ready.
- Opcodes (funct3):
  - 0 SET_OFFSET: input_offset <= in1 (32-bit signed); response = in1; IDLE->RESP.
  - 1 SET_ACC: acc[sel] <= sign-extend(in1) to ACC_W; response = in1; IDLE->RESP.
  - 2 MACC: IDLE->MUL.
    - MUL registers LANES products filt[k]*(inp[k]+input_offset), each ACC_W wide.
    - Next cycle: acc[sel] <= acc[sel] + sum(products), MUL->RESP.
    - Response = low 32 bits of the new acc[sel].
  - 3 GET_ACC: response = low 32 bits of acc[sel]; IDLE->RESP.
  - 4 GET_CLEAR: response = low 32 bits of acc[sel]; acc[sel] <= 0; IDLE->RESP.
  - 5..7: no state change; response_ok=0; response=0; IDLE->RESP.
- Latency: the accept cycle is T.
  - Non-MACC opcodes: rsp_valid at T+1.
  - MACC: rsp_valid at T+2.
- Response handshake:
  - In RESP, rsp_valid=1 and payload held stable until rsp_valid && rsp_ready; then RESP->IDLE.
  - cmd_ready returns to 1 the cycle after the handshake.
  - One command outstanding at most; a new command is never accepted in the same cycle as a response handshake.
- State update: accumulator and offset writes commit at the cycles stated above, independent of rsp_ready stalls.
- Arithmetic:
  - Operand (inp+offset) is computed at 33 bits signed; products and sum at ACC_W signed.
  - Default accumulation wraps modulo 2^ACC_W.
- Reset mid-operation (MUL or RESP): the pending command is aborted, no response is issued, and all state returns to reset values.

Optional Feature:
- Macro: CFU_MACC_SATURATE_EN.
- Defined: the MACC accumulator update saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - The sum is computed at ACC_W+log2(LANES)+2 bits before clamping.
  - SET_ACC, GET and GET_CLEAR are unchanged.
- Undefined: wrap-around as above; no extra logic.

Test Plan:
- Basic MACC: reset; SET_OFFSET in1=128; SET_ACC sel=0 in1=0; MACC sel=0, in1=0x01020304, in2=0xFFFFFFFF -> response 1270 (0x4F6), rsp_valid exactly 2 cycles after accept; GET_ACC sel=0 -> 1270.
- Back-pressure: MACC with rsp_ready held low 3 cycles -> rsp_valid stays 1, payload stable, cmd_ready=0 throughout; handshake on cycle 4; cmd_ready=1 the next cycle.
- Independent accumulators: SET_ACC sel=1 -> 100 and SET_ACC sel=2 -> -5; offset 0; MACC sel=1, in1=0x00000002, in2=0x00000003 -> 106; GET_ACC sel=2 -> 0xFFFFFFFB; GET_CLEAR sel=1 -> 106, then GET_ACC sel=1 -> 0.
- Overflow: offset 0; SET_ACC sel=0 in1=0x7FFFFFF0; MACC in1=0x00000001, in2=0x00000020 -> 0x80000010 without macro, 0x7FFFFFFF with CFU_MACC_SATURATE_EN.
- Illegal opcode and reset: funct3=7 -> response_ok=0, output 0, accumulators unchanged; assert reset during MUL of a MACC -> rsp_valid never rises, GET_ACC after reset -> 0, cmd_ready=1 immediately after reset deasserts.
- IN_W=16 build: offset 0; MACC in1=0xFFFF0002, in2=0x00030004 -> (-1*3)+(2*4) = 5.
